instr_fetch_unit: RTL and testbench

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

---
 rtl/instr_fetch_unit.sv | 88 ++++++++
 tb/tb_instr_fetch_unit.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: fetches one word per instruction from instruction memory,
// holds it for execution, then steps or branches the PC before the next fetch.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        CLK,
  input  logic        RESET,
  output logic        IMEM_READ,
  output logic [31:0] IMEM_ADDR,
  input  logic [31:0] IMEM_RDATA,
  input  logic        IMEM_BUSYWAIT,
  input  logic        STALL,
  input  logic        JUMP,
  input  logic        BRANCH,
  input  logic        ZERO,
  input  logic [7:0]  OFFSET,
  output logic [31:0] PC,
  output logic [31:0] INSTRUCTION,
  output logic        INSTR_VALID
);

  typedef enum logic [1:0] {S_RESET, S_FETCH, S_EXEC} state_t;

  state_t      state, state_next;
  logic [31:0] pc_q, pc_next;
  logic [31:0] instr_q, instr_next;
  logic        valid_q, valid_next;
  logic        read_q;
  logic [31:0] seq_pc, branch_offset;
  logic        take_target;

  // The offset counts words, so it is sign-extended and scaled to bytes.
  always_comb begin
    branch_offset = {{22{OFFSET[7]}}, OFFSET, 2'b00};
    seq_pc        = pc_q + PC_STEP;
    take_target   = JUMP | (BRANCH & ZERO);
  end

  always_comb begin
    state_next = state;
    pc_next    = pc_q;
    instr_next = instr_q;
    valid_next = valid_q;
    case (state)
      S_RESET: state_next = S_FETCH;
      S_FETCH: begin
        if (!IMEM_BUSYWAIT) begin
          instr_next = IMEM_RDATA;
          valid_next = 1'b1;
          state_next = S_EXEC;
        end
      end
      S_EXEC: begin
        if (!STALL) begin
          pc_next    = take_target ? (seq_pc + branch_offset) : seq_pc;
          valid_next = 1'b0;
          state_next = S_FETCH;
        end
      end
      default: state_next = S_RESET;
    endcase
  end

  // The read strobe gets its own flop so it never glitches on state decode.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state   <= S_RESET;
      pc_q    <= RESET_PC;
      instr_q <= 32'h0000_0000;
      valid_q <= 1'b0;
      read_q  <= 1'b0;
    end else begin
      state   <= state_next;
      pc_q    <= pc_next;
      instr_q <= instr_next;
      valid_q <= valid_next;
      read_q  <= (state_next == S_FETCH);
    end
  end

  assign IMEM_READ   = read_q;
  assign IMEM_ADDR   = pc_q;
  assign PC          = pc_q;
  assign INSTRUCTION = instr_q;
  assign INSTR_VALID = valid_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed testbench for instr_fetch_unit: each task drives one scenario and checks
// the outputs against hand-computed addresses and instruction words.
module tb_instr_fetch_unit;

  logic        CLK;
  logic        RESET;
  logic        IMEM_READ;
  logic [31:0] IMEM_ADDR;
  logic [31:0] IMEM_RDATA;
  logic        IMEM_BUSYWAIT;
  logic        STALL;
  logic        JUMP;
  logic        BRANCH;
  logic        ZERO;
  logic [7:0]  OFFSET;
  logic [31:0] PC;
  logic [31:0] INSTRUCTION;
  logic        INSTR_VALID;

  int tests_run = 0;
  int tests_failed = 0;

  instr_fetch_unit dut (
    .CLK(CLK), .RESET(RESET),
    .IMEM_READ(IMEM_READ), .IMEM_ADDR(IMEM_ADDR), .IMEM_RDATA(IMEM_RDATA),
    .IMEM_BUSYWAIT(IMEM_BUSYWAIT), .STALL(STALL), .JUMP(JUMP), .BRANCH(BRANCH),
    .ZERO(ZERO), .OFFSET(OFFSET), .PC(PC), .INSTRUCTION(INSTRUCTION),
    .INSTR_VALID(INSTR_VALID)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_ctrl;
    JUMP = 1'b0; BRANCH = 1'b0; ZERO = 1'b0; OFFSET = 8'h00; STALL = 1'b0;
  endtask

  task automatic test_reset;
    RESET = 1'b0; IMEM_RDATA = 32'h0; IMEM_BUSYWAIT = 1'b0; clear_ctrl();
    #2;
    tests_run++;
    if (PC !== 32'h0) begin tests_failed++; $display("[TB] FAIL reset_pc: got %h expected %h", PC, 32'h0); end
    tests_run++;
    if (INSTRUCTION !== 32'h0) begin tests_failed++; $display("[TB] FAIL reset_instr: got %h expected %h", INSTRUCTION, 32'h0); end
    tests_run++;
    if (INSTR_VALID !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_valid: got %b expected 0", INSTR_VALID); end
    tests_run++;
    if (IMEM_READ !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_read: got %b expected 0", IMEM_READ); end
    @(negedge CLK);
    RESET = 1'b1;
    IMEM_RDATA = 32'h0002_0103;
    tick();
    tests_run++;
    if (IMEM_READ !== 1'b1 || IMEM_ADDR !== 32'h0 || INSTR_VALID !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL first_request: got read=%b addr=%h valid=%b expected read=1 addr=0 valid=0", IMEM_READ, IMEM_ADDR, INSTR_VALID);
    end
    tick();
    tests_run++;
    if (INSTRUCTION !== 32'h0002_0103 || INSTR_VALID !== 1'b1 || PC !== 32'h0 || IMEM_READ !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL first_fetch: got instr=%h valid=%b pc=%h read=%b expected instr=00020103 valid=1 pc=0 read=0", INSTRUCTION, INSTR_VALID, PC, IMEM_READ);
    end
  endtask

  task automatic test_sequential;
    for (int i = 1; i <= 2; i++) begin
      IMEM_RDATA = 32'h1000_0000 + i;
      tick();
      tests_run++;
      if (IMEM_READ !== 1'b1 || IMEM_ADDR !== 32'(i * 4) || INSTR_VALID !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL seq_fetch_%0d: got read=%b addr=%h valid=%b expected read=1 addr=%h valid=0", i, IMEM_READ, IMEM_ADDR, INSTR_VALID, 32'(i * 4));
      end
      tick();
      tests_run++;
      if (INSTR_VALID !== 1'b1 || INSTRUCTION !== 32'h1000_0000 + i || PC !== 32'(i * 4)) begin
        tests_failed++;
        $display("[TB] FAIL seq_exec_%0d: got valid=%b instr=%h pc=%h expected valid=1 instr=%h pc=%h", i, INSTR_VALID, INSTRUCTION, PC, 32'h1000_0000 + i, 32'(i * 4));
      end
    end
  endtask

  task automatic test_jump_back;
    JUMP = 1'b1; OFFSET = 8'hFE;
    tick();
    clear_ctrl();
    tests_run++;
    if (IMEM_ADDR !== 32'h4 || IMEM_READ !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL jump_back: got addr=%h read=%b expected addr=00000004 read=1", IMEM_ADDR, IMEM_READ);
    end
  endtask

  task automatic test_busywait;
    IMEM_BUSYWAIT = 1'b1; IMEM_RDATA = 32'hDEAD_BEEF;
    JUMP = 1'b1; STALL = 1'b1; OFFSET = 8'h40;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests_run++;
      if (IMEM_ADDR !== 32'h4 || IMEM_READ !== 1'b1 || INSTRUCTION !== 32'h1000_0002 || INSTR_VALID !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL busy_hold_%0d: got addr=%h read=%b instr=%h valid=%b expected addr=4 read=1 instr=10000002 valid=0", i, IMEM_ADDR, IMEM_READ, INSTRUCTION, INSTR_VALID);
      end
    end
    clear_ctrl();
    IMEM_BUSYWAIT = 1'b0; IMEM_RDATA = 32'h2000_0004;
    tick();
    tests_run++;
    if (INSTRUCTION !== 32'h2000_0004 || INSTR_VALID !== 1'b1 || PC !== 32'h4) begin
      tests_failed++;
      $display("[TB] FAIL busy_release: got instr=%h valid=%b pc=%h expected instr=20000004 valid=1 pc=4", INSTRUCTION, INSTR_VALID, PC);
    end
    IMEM_RDATA = 32'hFFFF_FFFF; IMEM_BUSYWAIT = 1'b1;
    tick();
    IMEM_RDATA = 32'h3000_0008; IMEM_BUSYWAIT = 1'b0;
    tick();
    tests_run++;
    if (INSTRUCTION !== 32'h3000_0008 || PC !== 32'h8 || INSTR_VALID !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL fetch_at_8: got instr=%h pc=%h valid=%b expected instr=30000008 pc=8 valid=1", INSTRUCTION, PC, INSTR_VALID);
    end
  endtask

  task automatic test_branch;
    BRANCH = 1'b1; ZERO = 1'b0; OFFSET = 8'h03;
    tick();
    clear_ctrl();
    tests_run++;
    if (IMEM_ADDR !== 32'hC) begin tests_failed++; $display("[TB] FAIL branch_not_taken: got %h expected %h", IMEM_ADDR, 32'hC); end
    tick();
    JUMP = 1'b1; BRANCH = 1'b1; ZERO = 1'b0; OFFSET = 8'hFE;
    tick();
    clear_ctrl();
    tests_run++;
    if (IMEM_ADDR !== 32'h8) begin tests_failed++; $display("[TB] FAIL jump_over_branch: got %h expected %h", IMEM_ADDR, 32'h8); end
    tick();
    BRANCH = 1'b1; ZERO = 1'b1; OFFSET = 8'h03;
    tick();
    clear_ctrl();
    tests_run++;
    if (IMEM_ADDR !== 32'h18) begin tests_failed++; $display("[TB] FAIL branch_taken: got %h expected %h", IMEM_ADDR, 32'h18); end
    IMEM_RDATA = 32'h4000_0018;
    tick();
  endtask

  task automatic test_stall;
    STALL = 1'b1; JUMP = 1'b0; OFFSET = 8'h01;
    for (int i = 0; i < 2; i++) begin
      tick();
      JUMP = ~JUMP;
      tests_run++;
      if (PC !== 32'h18 || INSTRUCTION !== 32'h4000_0018 || INSTR_VALID !== 1'b1 || IMEM_READ !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL stall_hold_%0d: got pc=%h instr=%h valid=%b read=%b expected pc=18 instr=40000018 valid=1 read=0", i, PC, INSTRUCTION, INSTR_VALID, IMEM_READ);
      end
    end
    STALL = 1'b0; JUMP = 1'b1;
    tick();
    clear_ctrl();
    tests_run++;
    if (IMEM_ADDR !== 32'h20 || INSTR_VALID !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL stall_release: got addr=%h valid=%b expected addr=00000020 valid=0", IMEM_ADDR, INSTR_VALID);
    end
    tick();
  endtask

  task automatic test_wrap;
    JUMP = 1'b1; OFFSET = 8'hF7;
    tick();
    clear_ctrl();
    tests_run++;
    if (IMEM_ADDR !== 32'h0) begin tests_failed++; $display("[TB] FAIL jump_to_zero: got %h expected %h", IMEM_ADDR, 32'h0); end
    tick();
    JUMP = 1'b1; OFFSET = 8'hFE;
    tick();
    clear_ctrl();
    tests_run++;
    if (IMEM_ADDR !== 32'hFFFF_FFFC) begin tests_failed++; $display("[TB] FAIL wrap_negative: got %h expected %h", IMEM_ADDR, 32'hFFFF_FFFC); end
    tick();
    tick();
    tests_run++;
    if (IMEM_ADDR !== 32'h0 || IMEM_READ !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL wrap_sequential: got addr=%h read=%b expected addr=0 read=1", IMEM_ADDR, IMEM_READ);
    end
    tick();
  endtask

  task automatic test_reset_midfetch;
    JUMP = 1'b1; OFFSET = 8'h03;
    tick();
    clear_ctrl();
    IMEM_BUSYWAIT = 1'b1;
    tests_run++;
    if (IMEM_ADDR !== 32'h10 || IMEM_READ !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL pre_reset_fetch: got addr=%h read=%b expected addr=10 read=1", IMEM_ADDR, IMEM_READ);
    end
    #3;
    RESET = 1'b0;
    #1;
    tests_run++;
    if (IMEM_READ !== 1'b0 || PC !== 32'h0 || INSTR_VALID !== 1'b0 || INSTRUCTION !== 32'h0) begin
      tests_failed++;
      $display("[TB] FAIL async_reset: got read=%b pc=%h valid=%b instr=%h expected read=0 pc=0 valid=0 instr=0", IMEM_READ, PC, INSTR_VALID, INSTRUCTION);
    end
    #2;
    RESET = 1'b1;
    IMEM_BUSYWAIT = 1'b0; IMEM_RDATA = 32'h5000_0000;
    tick();
    tests_run++;
    if (IMEM_READ !== 1'b1 || IMEM_ADDR !== 32'h0 || INSTR_VALID !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL refetch_request: got read=%b addr=%h valid=%b expected read=1 addr=0 valid=0", IMEM_READ, IMEM_ADDR, INSTR_VALID);
    end
    tick();
    tests_run++;
    if (INSTRUCTION !== 32'h5000_0000 || INSTR_VALID !== 1'b1 || PC !== 32'h0) begin
      tests_failed++;
      $display("[TB] FAIL refetch_done: got instr=%h valid=%b pc=%h expected instr=50000000 valid=1 pc=0", INSTRUCTION, INSTR_VALID, PC);
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_jump_back();
    test_busywait();
    test_branch();
    test_stall();
    test_wrap();
    test_reset_midfetch();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
